// File: rtl/arch_defs_pkg.sv
// Shared architecture definitions: data width, ALU opcodes and the ALU arbiter state type.
package arch_defs_pkg;

    localparam int DATA_WIDTH = 8;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;

    localparam int ALU_ARB_NUM_PORTS = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } alu_arb_state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way combinational winner select for the ALU arbiter.
// ALU_ARB_ROUND_ROBIN_EN selects round-robin on contention; otherwise port 0 has fixed priority.
module rr_arbiter2
    import arch_defs_pkg::*;
(
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [ALU_ARB_NUM_PORTS-1:0] valid,
    input  logic                         accept,
    output logic [ALU_ARB_NUM_PORTS-1:0] grant
);

`ifdef ALU_ARB_ROUND_ROBIN_EN
    // Remembers which port won the previous accept; starts at 1 so port 0 wins first.
    logic last_grant;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            last_grant <= 1'b1;
        end else if (accept) begin
            last_grant <= grant[1];
        end
    end

    always_comb begin
        grant = '0;
        if (valid == 2'b11) begin
            if (last_grant) begin
                grant[0] = 1'b1;
            end else begin
                grant[1] = 1'b1;
            end
        end else begin
            grant = valid;
        end
    end
`else
    logic unused_pins;
    assign unused_pins = &{1'b0, clk, reset_n, accept};

    always_comb begin
        grant = '0;
        if (valid[0]) begin
            grant[0] = 1'b1;
        end else if (valid[1]) begin
            grant[1] = 1'b1;
        end
    end
`endif

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between two requesters: accept -> EXEC -> RESP, tagged done pulse.
// Optional round-robin arbitration via ALU_ARB_ROUND_ROBIN_EN (fixed port-0 priority otherwise).
module alu_arbiter #(
    parameter int DATA_WIDTH = arch_defs_pkg::DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [1:0]            req0_op,
    input  logic [DATA_WIDTH-1:0] req0_a,
    input  logic [DATA_WIDTH-1:0] req0_b,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [1:0]            req1_op,
    input  logic [DATA_WIDTH-1:0] req1_a,
    input  logic [DATA_WIDTH-1:0] req1_b,
    output logic [DATA_WIDTH-1:0] alu_a,
    output logic [DATA_WIDTH-1:0] alu_b,
    output logic [1:0]            alu_op,
    input  logic [DATA_WIDTH-1:0] alu_result,
    input  logic                  alu_zero,
    input  logic                  alu_carry,
    input  logic                  alu_negative,
    output logic                  rsp_done0,
    output logic                  rsp_done1,
    output logic [DATA_WIDTH-1:0] rsp_result,
    output logic                  rsp_zero,
    output logic                  rsp_carry,
    output logic                  rsp_negative,
    output logic                  busy
);
    import arch_defs_pkg::*;

    alu_arb_state_t                 state_q;
    alu_arb_state_t                 state_d;
    logic [ALU_ARB_NUM_PORTS-1:0]   grant;
    logic                           accept;
    logic                           id_q;
    logic                           zero_hold;
    logic                           carry_hold;
    logic                           negative_hold;

    rr_arbiter2 u_rr_arbiter2 (
        .clk     (clk),
        .reset_n (reset_n),
        .valid   ({req1_valid, req0_valid}),
        .accept  (accept),
        .grant   (grant)
    );

    // Ready only in IDLE and never while reset is held, so no transfer can be implied.
    assign req0_ready = reset_n && (state_q == IDLE) && grant[0];
    assign req1_ready = reset_n && (state_q == IDLE) && grant[1];
    assign accept     = req0_ready | req1_ready;
    assign busy       = (state_q != IDLE);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            alu_a         <= '0;
            alu_b         <= '0;
            alu_op        <= ALU_ADD;
            id_q          <= 1'b0;
            zero_hold     <= 1'b0;
            carry_hold    <= 1'b0;
            negative_hold <= 1'b0;
            rsp_result    <= '0;
            rsp_zero      <= 1'b0;
            rsp_carry     <= 1'b0;
            rsp_negative  <= 1'b0;
            rsp_done0     <= 1'b0;
            rsp_done1     <= 1'b0;
        end else begin
            state_q   <= state_d;
            rsp_done0 <= 1'b0;
            rsp_done1 <= 1'b0;

            if (accept) begin
                alu_op <= req1_ready ? req1_op : req0_op;
                alu_a  <= req1_ready ? req1_a  : req0_a;
                alu_b  <= req1_ready ? req1_b  : req0_b;
                id_q   <= req1_ready;
            end

            // Flags are combinational from the held operands; the result latches on this same edge.
            if (state_q == EXEC) begin
                zero_hold     <= alu_zero;
                carry_hold    <= alu_carry;
                negative_hold <= alu_negative;
            end

            if (state_q == RESP) begin
                rsp_result   <= alu_result;
                rsp_zero     <= zero_hold;
                rsp_carry    <= carry_hold;
                rsp_negative <= negative_hold;
                rsp_done0    <= ~id_q;
                rsp_done1    <= id_q;
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter with a behavioural ALU and a response scoreboard.
// Grant-order expectations follow ALU_ARB_ROUND_ROBIN_EN when it is defined.
module tb_alu_arbiter;
    import arch_defs_pkg::*;

    localparam int W = 8;
`ifdef ALU_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset_n;
    logic         req0_valid, req1_valid;
    logic         req0_ready, req1_ready;
    logic [1:0]   req0_op, req1_op;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [W-1:0] alu_a, alu_b, alu_result;
    logic [1:0]   alu_op;
    logic         alu_zero, alu_carry, alu_negative;
    logic         rsp_done0, rsp_done1;
    logic [W-1:0] rsp_result;
    logic         rsp_zero, rsp_carry, rsp_negative;
    logic         busy;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int done0_cnt = 0;
    int done1_cnt = 0;

    typedef struct {
        logic         port;
        logic [W-1:0] res;
        logic         z, c, n;
        int           acc;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_arbiter #(.DATA_WIDTH(W)) dut (
        .clk(clk), .reset_n(reset_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_result(alu_result), .alu_zero(alu_zero), .alu_carry(alu_carry),
        .alu_negative(alu_negative),
        .rsp_done0(rsp_done0), .rsp_done1(rsp_done1), .rsp_result(rsp_result),
        .rsp_zero(rsp_zero), .rsp_carry(rsp_carry), .rsp_negative(rsp_negative),
        .busy(busy)
    );

    // Carry is the 9th bit: carry-out for ADD, borrow for SUB.
    function automatic logic [W:0] alu_calc(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        case (op)
            ALU_ADD: return {1'b0, a} + {1'b0, b};
            ALU_SUB: return {1'b0, a} - {1'b0, b};
            ALU_AND: return {1'b0, a & b};
            default: return {1'b0, a | b};
        endcase
    endfunction

    // Behavioural ALU: combinational flags, result latched every rising edge.
    logic [W:0]   alu_full;
    logic [W-1:0] alu_latched = '0;
    assign alu_full     = alu_calc(alu_op, alu_a, alu_b);
    assign alu_zero     = (alu_full[W-1:0] == '0);
    assign alu_carry    = alu_full[W];
    assign alu_negative = alu_full[W-1];
    always @(posedge clk) alu_latched <= alu_full[W-1:0];
    assign alu_result   = alu_latched;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    function automatic exp_t make_exp(input logic port, input logic [1:0] op,
                                      input logic [W-1:0] a, input logic [W-1:0] b, input int acc);
        exp_t e;
        logic [W:0] f;
        f     = alu_calc(op, a, b);
        e.port = port;
        e.res  = f[W-1:0];
        e.z    = (f[W-1:0] == '0);
        e.c    = f[W];
        e.n    = f[W-1];
        e.acc  = acc;
        return e;
    endfunction

    // Scoreboard monitor: pushes on every observed transfer, pops on every done pulse.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!reset_n) begin
            sb.delete();
        end else begin
            if (req0_ready || req1_ready)
                check("ready_onehot", {31'd0, req0_ready & req1_ready}, 32'd0);
            if (rsp_done0 || rsp_done1) begin
                if (rsp_done0) done0_cnt++;
                if (rsp_done1) done1_cnt++;
                if (sb.size() == 0) begin
                    check("done_unexpected", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("sb_done_port", {30'd0, rsp_done1, rsp_done0}, e.port ? 32'd2 : 32'd1);
                    check("sb_latency", cyc - e.acc, 32'd3);
                    check("sb_result", rsp_result, e.res);
                    check("sb_zero", rsp_zero, e.z);
                    check("sb_carry", rsp_carry, e.c);
                    check("sb_negative", rsp_negative, e.n);
                end
            end
            if (req0_valid && req0_ready) sb.push_back(make_exp(1'b0, req0_op, req0_a, req0_b, cyc));
            if (req1_valid && req1_ready) sb.push_back(make_exp(1'b1, req1_op, req1_a, req1_b, cyc));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a request and hold it until accepted; returns in the EXEC cycle.
    task automatic issue(input logic port, input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        bit got = 1'b0;
        if (port) begin
            req1_op = op; req1_a = a; req1_b = b; req1_valid = 1'b1;
        end else begin
            req0_op = op; req0_a = a; req0_b = b; req0_valid = 1'b1;
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (port ? req1_ready : req0_ready) begin
                got = 1'b1;
                break;
            end
        end
        check("accept_seen", {31'd0, got}, 32'd1);
        step();
        if (port) req1_valid = 1'b0; else req0_valid = 1'b0;
    endtask

    task automatic run_op(input logic port, input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] res, input logic z, input logic c, input logic n);
        bit got = 1'b0;
        issue(port, op, a, b);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rsp_done0 || rsp_done1) begin
                got = 1'b1;
                break;
            end
        end
        check("done_seen", {31'd0, got}, 32'd1);
        check("done0", {31'd0, rsp_done0}, {31'd0, ~port});
        check("done1", {31'd0, rsp_done1}, {31'd0, port});
        check("result", rsp_result, res);
        check("zero", rsp_zero, z);
        check("carry", rsp_carry, c);
        check("negative", rsp_negative, n);
        step();
    endtask

    initial begin : stimulus
        int grants[4];
        int acc_cyc[4];
        int nacc;
        int d0;
        bit got;

        reset_n = 1'b0;
        req0_valid = 1'b1; req0_op = ALU_OR;  req0_a = 8'h55; req0_b = 8'hAA;
        req1_valid = 1'b1; req1_op = ALU_SUB; req1_a = 8'h12; req1_b = 8'h34;
        repeat (3) step();
        @(negedge clk);
        check("rst_ready0", req0_ready, 0);
        check("rst_ready1", req1_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_done", {rsp_done1, rsp_done0}, 0);
        check("rst_result", rsp_result, 0);
        check("rst_flags", {rsp_zero, rsp_carry, rsp_negative}, 0);
        check("rst_alu_ab", {alu_a, alu_b}, 0);
        check("rst_alu_op", alu_op, ALU_ADD);
        step();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        reset_n = 1'b1;
        step();

        run_op(1'b0, ALU_ADD, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 1'b1);
        run_op(1'b1, ALU_ADD, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0);
        run_op(1'b0, ALU_SUB, 8'h03, 8'h05, 8'hFE, 1'b0, 1'b1, 1'b1);
        run_op(1'b0, ALU_AND, 8'hF0, 8'h0F, 8'h00, 1'b1, 1'b0, 1'b0);
        run_op(1'b0, ALU_AND, 8'hF0, 8'h30, 8'h30, 1'b0, 1'b0, 1'b0);
        run_op(1'b1, ALU_OR,  8'h80, 8'h01, 8'h81, 1'b0, 1'b0, 1'b1);

        // Continuous contention for four accepts.
        req0_op = ALU_ADD; req0_a = 8'h11; req0_b = 8'h22; req0_valid = 1'b1;
        req1_op = ALU_SUB; req1_a = 8'h10; req1_b = 8'h20; req1_valid = 1'b1;
        nacc = 0;
        for (int i = 0; i < 40 && nacc < 4; i++) begin
            @(negedge clk);
            if (req0_ready) begin
                grants[nacc] = 0; acc_cyc[nacc] = cyc; nacc++;
            end else if (req1_ready) begin
                grants[nacc] = 1; acc_cyc[nacc] = cyc; nacc++;
            end
        end
        step();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        check("contention_accepts", nacc, 4);
        for (int i = 0; i < nacc; i++) begin
            check("contention_grant", grants[i], RR ? (i % 2) : 0);
            if (i > 0) check("contention_spacing", acc_cyc[i] - acc_cyc[i-1], 3);
        end
        repeat (6) step();

        // Reset during EXEC abandons the operation.
        d0 = done0_cnt;
        issue(1'b0, ALU_ADD, 8'h01, 8'h02);
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        @(negedge clk);
        check("midrst_busy", busy, 0);
        check("midrst_result", rsp_result, 0);
        check("midrst_flags", {rsp_zero, rsp_carry, rsp_negative}, 0);
        check("midrst_alu_ab", {alu_a, alu_b}, 0);
        check("midrst_alu_op", alu_op, ALU_ADD);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("midrst_no_done", {rsp_done1, rsp_done0}, 0);
        end
        check("midrst_done0_cnt", done0_cnt, d0);
        step();
        run_op(1'b1, ALU_AND, 8'hF0, 8'h30, 8'h30, 1'b0, 1'b0, 1'b0);

        // Port 0 withdraws its request while port 1 is being served.
        d0 = done0_cnt;
        issue(1'b1, ALU_OR, 8'h0E, 8'h01);
        req0_op = ALU_ADD; req0_a = 8'h01; req0_b = 8'h01; req0_valid = 1'b1;
        @(negedge clk);
        check("withdraw_ready0", req0_ready, 0);
        check("withdraw_busy", busy, 1);
        step();
        req0_valid = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rsp_done0 || rsp_done1) begin
                got = 1'b1;
                break;
            end
        end
        check("withdraw_done_seen", got, 1);
        check("withdraw_done1", rsp_done1, 1);
        check("withdraw_result", rsp_result, 8'h0F);
        repeat (4) @(negedge clk);
        check("withdraw_no_done0", done0_cnt, d0);
        check("sb_drained", sb.size(), 0);

        repeat (3) step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-port arbiter and sequencer that shares the single SAP-1.5 ALU between two requesters: port 0 is the control unit and port 1 is an auxiliary engine (checksum/DMA). It accepts one operation at a time over a valid/ready handshake and drives the ALU's operand and opcode inputs from held registers. It captures the ALU's combinational flags and its one-cycle-latched result, then returns a tagged response with a single-cycle done pulse.

## Interface
- DATA_WIDTH, default arch_defs_pkg::DATA_WIDTH (8), operand/result width.
- clk  in  1  system clock, all logic on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- req0_valid / req1_valid  in  1  request pending on port 0 / 1.
- req0_ready / req1_ready  out  1  combinational accept strobe; transfer when valid & ready.
- req0_op / req1_op  in  2  ALU opcode (ALU_ADD/SUB/AND/OR from arch_defs_pkg).
- req0_a, req0_b / req1_a, req1_b  in  DATA_WIDTH  operands.
- alu_a, alu_b  out  DATA_WIDTH  to ALU a_in/b_in, registered.
- alu_op  out  2  to ALU alu_op, registered.
- alu_result  in  DATA_WIDTH  from ALU latched_result.
- alu_zero, alu_carry, alu_negative  in  1  from ALU combinational flags.
- rsp_done0 / rsp_done1  out  1  one-cycle completion pulse for port 0 / 1.
- rsp_result  out  DATA_WIDTH  result of last completed op, registered.
- rsp_zero, rsp_carry, rsp_negative  out  1  flags of last completed op, registered.
- busy  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If no valid is asserted, stay in IDLE.
  - Otherwise pick a winner, assert ready only to the winner, and latch op/a/b into alu_op/alu_a/alu_b. Record the winner id, then go to EXEC.
- EXEC:
  - ALU inputs are stable from the registers.
  - Register alu_zero/alu_carry/alu_negative into internal flag holds.
  - Go to RESP. The ALU latches its result on this edge.
- RESP:
  - alu_result is valid.
  - Load rsp_result with alu_result and load rsp_* flags from the flag holds.
  - Pulse rsp_done[id] and go to IDLE.
- alu_a/alu_b/alu_op hold their last values outside EXEC. The ALU is never fed undriven inputs.
- The arbiter passes ALU results and flags through unchanged. It does no arithmetic of its own.
- rsp_* outputs hold their value until the next completion.
- Requesters must hold valid/op/a/b stable until ready. Dropping valid before ready is allowed and means no transfer.
- Port-0 priority (macro off): when both ports are valid, port 0 wins.

## Timing
- Accept in cycle T, EXEC in T+1, RESP in T+2. rsp_done and rsp_result are visible in T+3.
- The block is back in IDLE in T+3, so a new accept can occur in T+3 in the same cycle as done is high. Throughput is one op per 3 cycles.
- ready is asserted only in IDLE and is never asserted to both ports in the same cycle.
- Reset values: state IDLE, ready 0, busy 0, rsp_done0/1 0, rsp_result 0, rsp flags 0, alu_a/alu_b 0, alu_op ALU_ADD, last-grant pointer = port 1.
- Reset mid-operation: the operation in flight is abandoned with no done pulse. The FSM returns to IDLE on the next edge.
- The ALU's own reset is separate. After reset_n is released, alu_result is treated as don't-care until the first RESP.

## Configuration
- ALU_ARB_ROUND_ROBIN_EN defined:
  - When both ports are valid, the port not granted last wins.
  - The last-grant pointer updates on every accept.
  - After reset the pointer is 1, so port 0 wins the first contention.
- ALU_ARB_ROUND_ROBIN_EN undefined: fixed port-0 priority, and the pointer logic is removed.
- A single valid port is granted immediately in both modes.

## Structure
- arch_defs_pkg: add alu_arb_state_t enum (IDLE, EXEC, RESP) and ALU_ARB_NUM_PORTS = 2. Reuse the existing ALU_* opcode constants.
- Sub-module rr_arbiter2 picks the winner combinationally from the two valids and the last-grant pointer, and owns the pointer register.
- The FSM, operand/flag registers and response registers live in the top module.

## Test plan
- Port 0: ADD 0x7F + 0x01 accepted at T → rsp_done0 at T+3, result 0x80, N=1, Z=0, C=0.
- Port 1: ADD 0xFF + 0x01 → rsp_done1, result 0x00, Z=1, C=1, N=0. rsp_done0 stays low.
- SUB 0x03 − 0x05 → result 0xFE, C=1, N=1. Then AND 0xF0 & 0x0F → 0x00, Z=1, C=0, N=0. Also AND 0xF0 & 0x30 → 0x30, Z=0, N=0, and OR 0x80 | 0x01 → 0x81, N=1, C=0.
- Both ports valid continuously for 4 ops:
  - Round-robin defined: grants go 0,1,0,1.
  - Round-robin undefined: grants go 0,0,0,0 while port 1 sees ready=0 throughout.
  - Back-to-back accepts occur every 3 cycles.
- reset_n low during EXEC → no rsp_done in the following cycles, state IDLE, outputs at reset values, and the next request completes normally.
- Port 0 valid deasserted before it is granted (port 1 busy) → no transfer on port 0 and no rsp_done0.
